fifo_rd_ctrl: RTL and testbench

Read-side controller for the style-#2 asynchronous FIFO. Consumes the comparator's asynchronous `aempty_n` flag, owns the Gray-coded read pointer fed back to the comparator, addresses the dual-port memory, and presents popped words on a registered valid/ready output stage. Sits entirely in the read clock domain, opposite the write-side pointer/full controller.

---
 rtl/fifo_rd_ctrl.sv | 80 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a style-#2 asynchronous FIFO.
// Owns the binary read address and the registered Gray read pointer,
// synchronizes the comparator's asynchronous empty flag into rclk, and
// presents popped words on a registered valid/ready output stage.
module fifo_rd_ctrl #(
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned DSIZE    = 8
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                aempty_n,
  input  logic [DSIZE-1:0]    rdata,
  input  logic                dout_ready,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE-1:0] rptr,
  output logic                rempty,
  output logic [DSIZE-1:0]    dout,
  output logic                dout_valid
);

  logic [ADDRSIZE-1:0] rbin;
  logic [ADDRSIZE-1:0] rbin_nxt;
  logic [ADDRSIZE-1:0] rgray_nxt;
  logic                s1;
  logic                s2;
  logic                pop;
  logic                accept;

  // Next pointer values and the pop/accept decision.
  always_comb begin
    rbin_nxt  = rbin + ADDRSIZE'(1);
    rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1);
    rempty    = ~s2;
    pop       = ~rempty & (~dout_valid | dout_ready);
    accept    = dout_valid & dout_ready;
    raddr     = rbin;
  end

  // Empty-flag synchronizer; flushed on every pop so the next pop waits for
  // the comparator to re-evaluate against the advanced rptr.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (pop) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= aempty_n;
      s2 <= s1;
    end
  end

  // Binary address and Gray pointer advance together; rptr is a direct
  // register output so the comparator never sees a glitch.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin <= '0;
      rptr <= '0;
    end else if (pop) begin
      rbin <= rbin_nxt;
      rptr <= rgray_nxt;
    end
  end

  // Output register: a pop loads a new word even when the old one is being
  // accepted in the same cycle.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (pop) begin
      dout       <= rdata;
      dout_valid <= 1'b1;
    end else if (accept) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a cycle-level reference model and
// hand-computed checkpoints.
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       aempty_n;
  logic [7:0] rdata;
  logic       dout_ready;
  logic [3:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic [7:0] dout;
  logic       dout_valid;

  int checks = 0;
  int errs   = 0;

  logic [7:0] mem [16];

  // Reference model state: pops so far, consecutive not-empty samples since
  // the last pop/reset, and the expected output register.
  int         m_npop = 0;
  int         m_run  = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_dout = '0;
  bit         m_ok = 1'b0;

  fifo_rd_ctrl #(.ADDRSIZE(4), .DSIZE(8)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .aempty_n   (aempty_n),
    .rdata      (rdata),
    .dout_ready (dout_ready),
    .raddr      (raddr),
    .rptr       (rptr),
    .rempty     (rempty),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 rclk = ~rclk;

  // Combinational dual-port memory read.
  assign rdata = mem[raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] gray(input int n);
    logic [3:0] b;
    b = 4'(n % 16);
    return b ^ (b >> 1);
  endfunction

  // Model: a pop needs two consecutive not-empty samples since the last pop.
  always @(posedge rclk) begin
    if (!rrst_n) begin
      m_npop = 0; m_run = 0; m_valid = 1'b0; m_dout = '0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (m_run >= 2 && (!m_valid || dout_ready)) begin
        m_dout  = mem[m_npop % 16];
        m_valid = 1'b1;
        m_npop++;
        m_run   = 0;
      end else begin
        m_run = aempty_n ? ((m_run >= 2) ? 2 : m_run + 1) : 0;
        if (m_valid && dout_ready) m_valid = 1'b0;
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge rclk) begin
    if (m_ok) begin
      chk("m_rptr",   32'(rptr),       32'(gray(m_npop)));
      chk("m_raddr",  32'(raddr),      32'(m_npop % 16));
      chk("m_rempty", 32'(rempty),     32'(m_run < 2));
      chk("m_valid",  32'(dout_valid), 32'(m_valid));
      chk("m_dout",   32'(dout),       32'(m_dout));
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  logic [3:0] prev;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hA5 ^ 8'(i * 8'h11);
    rrst_n = 1'b0; aempty_n = 1'b1; dout_ready = 1'b1;

    // Reset with aempty_n high.
    tick();
    chk("rst_rptr", 32'(rptr), 32'h0);
    chk("rst_raddr", 32'(raddr), 32'h0);
    chk("rst_rempty", 32'(rempty), 32'h1);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    rrst_n = 1'b1;

    // First pop lands on the third edge after release.
    tick(); tick();
    chk("lat_rempty", 32'(rempty), 32'h0);
    chk("lat_valid", 32'(dout_valid), 32'h0);
    tick();
    chk("sw_dout", 32'(dout), 32'hA5);
    chk("sw_valid", 32'(dout_valid), 32'h1);
    chk("sw_rptr", 32'(rptr), 32'h1);
    chk("sw_rempty", 32'(rempty), 32'h1);

    // Stall: output held, pointer frozen.
    dout_ready = 1'b0;
    repeat (6) begin
      tick();
      chk("stall_dout", 32'(dout), 32'hA5);
      chk("stall_rptr", 32'(rptr), 32'h1);
      chk("stall_valid", 32'(dout_valid), 32'h1);
    end
    chk("stall_rempty", 32'(rempty), 32'h0);

    // Release: pop on the same edge, then one pop per 3 cycles through wrap.
    dout_ready = 1'b1;
    tick();
    chk("rel_dout", 32'(dout), 32'hB4);
    chk("rel_rptr", 32'(rptr), 32'h3);
    prev = rptr;
    repeat (42) begin
      tick();
      chk("gray_step", 32'($countones(rptr ^ prev) <= 1), 32'h1);
      prev = rptr;
    end
    chk("wrap_rptr", 32'(rptr), 32'h0);
    chk("wrap_raddr", 32'(raddr), 32'h0);
    chk("wrap_dout", 32'(dout), 32'h5A);

    // Empty boundary: flag drops right after the pop.
    aempty_n = 1'b0; dout_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("emp_valid_hold", 32'(dout_valid), 32'h1);
      chk("emp_rempty", 32'(rempty), 32'h1);
    end
    dout_ready = 1'b1;
    repeat (5) begin
      tick();
      chk("emp_valid_clr", 32'(dout_valid), 32'h0);
      chk("emp_rptr", 32'(rptr), 32'h0);
      chk("emp_rempty2", 32'(rempty), 32'h1);
    end

    // Reset mid-operation after four pops (rptr = 0110).
    rrst_n = 1'b0; tick(); rrst_n = 1'b1; aempty_n = 1'b1;
    repeat (12) tick();
    chk("mid_rptr", 32'(rptr), 32'h6);
    chk("mid_valid", 32'(dout_valid), 32'h1);
    rrst_n = 1'b0;
    tick();
    chk("mid_rst_rptr", 32'(rptr), 32'h0);
    chk("mid_rst_raddr", 32'(raddr), 32'h0);
    chk("mid_rst_rempty", 32'(rempty), 32'h1);
    chk("mid_rst_valid", 32'(dout_valid), 32'h0);
    chk("mid_rst_dout", 32'(dout), 32'h0);
    rrst_n = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", checks, errs);
    $finish;
  end

endmodule
